condlogic_stack: RTL and testbench
==================================

Name: condlogic_stack

Overview:
- Parametrised next-generation conditional-execution unit for the ARM cores.
- Holds the NZCV flag register and evaluates the full 4-bit ARM condition field.
- Gates register, memory, PC and flag writes on the condition result.
- Adds configurable flag-write granularity and a LIFO flag save/restore stack (exception/interrupt nesting) with full/empty/error status.

Parameters:
FLAG_GROUPS, 2, number of independently write-enabled flag groups; legal values 1, 2, 4; group g covers Flags[(4/FLAG_GROUPS)*(g+1)-1 : (4/FLAG_GROUPS)*g] (default 2: group1=NZ, group0=CV)
SAVE_DEPTH, 4, flag stack entries; legal 1..16

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Cond  input  4  instruction condition field
ALUFlags  input  4  {N,Z,C,V} from ALU this cycle
FlagW  input  FLAG_GROUPS  per-group flag write request
PCS  input  1  PC-write request
RegW  input  1  register-write request
MemW  input  1  memory-write request
NoWrite  input  1  suppress register write (CMP/TST class)
FlagSave  input  1  push current Flags onto stack
FlagRestore  input  1  pop stack top into Flags
PCSrc  output  1  PCS & CondEx
RegWrite  output  1  RegW & CondEx & ~NoWrite
MemWrite  output  1  MemW & CondEx
CondEx  output  1  condition result
Flags  output  4  committed {N,Z,C,V}
carry  output  1  Flags[1]
StackDepth  output  $clog2(SAVE_DEPTH+1)  occupied entries
StackFull  output  1  StackDepth == SAVE_DEPTH
StackEmpty  output  1  StackDepth == 0
StackErr  output  1  sticky error flag

Behaviour:
- Reset (async): Flags=0, stack entries=0, StackDepth=0, StackErr=0. Hence StackEmpty=1, StackFull=0, carry=0. CondEx follows Cond against Flags=0, e.g. EQ->0, AL->1.
- CondEx is combinational from Cond and the committed Flags only; ALUFlags are never forwarded.
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V.
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F 1 (unconditional space).
- PCSrc/RegWrite/MemWrite are combinational, zero latency.
- Flag write: at clk edge, group g loads its ALUFlags slice when FlagW[g] & CondEx. Other groups hold.
- Push (FlagSave=1, FlagRestore=0):
  - Not full: stack[StackDepth] <= Flags (value before any same-cycle flag write); StackDepth+1.
  - A same-cycle flag write still updates Flags normally.
  - Full: push dropped, StackDepth unchanged, StackErr<=1.
- Pop (FlagRestore=1, FlagSave=0):
  - Not empty: Flags <= stack[StackDepth-1]; StackDepth-1.
  - Restore overrides any same-cycle FlagW write, for all groups.
  - Empty: Flags updated by FlagW as normal, StackDepth stays 0, StackErr<=1.
- FlagSave & FlagRestore together: stack and StackDepth unchanged, FlagW write proceeds normally, StackErr<=1.
- StackErr is cleared only by reset.
- StackDepth never wraps: it saturates at 0 and SAVE_DEPTH via the rules above.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Test Plan:
1. Reset, Flags=0, Cond=0 (EQ) -> CondEx=0. Cond=E -> CondEx=1. StackEmpty=1, StackErr=0.
2. Cond=E, FlagW=2'b11, ALUFlags=4'b0110 -> next cycle Flags=0110, carry=1. Then Cond=0 (EQ), RegW=1, NoWrite=0 -> RegWrite=1. Then NoWrite=1 -> RegWrite=0.
3. Flags=0110, Cond=1 (NE, false), FlagW=2'b11, ALUFlags=1001, MemW=1 -> MemWrite=0 and Flags stay 0110. Cond=E, FlagW=2'b01 -> Flags=0101 (NZ group held).
4. With SAVE_DEPTH=4:
   - Push 1000, 0100, 0010, 0001 -> StackFull=1, StackDepth=4.
   - 5th push -> StackErr=1, depth 4.
   - Four pops -> Flags = 0001, 0010, 0100, 1000 in order; StackEmpty=1.
   - 5th pop -> Flags unchanged, StackErr stays 1.
5. Flags=0011, FlagSave=1, Cond=E, FlagW=2'b11, ALUFlags=1100 -> stack top=0011, Flags=1100. Next cycle FlagRestore=1 with FlagW=2'b11, ALUFlags=1111 -> Flags=0011.
6. FlagSave=FlagRestore=1 at depth 2 -> depth 2, StackErr=1. Then assert reset between clock edges -> Flags=0, depth 0, StackErr=0 immediately.

Source files
------------

// File: rtl/condlogic_stack.sv
// Conditional-execution unit: NZCV flag register, ARM condition evaluation,
// write gating, grouped flag writes and a LIFO flag save/restore stack.
module condlogic_stack #(
    parameter int FLAG_GROUPS = 2,
    parameter int SAVE_DEPTH  = 4,
    localparam int DW = $clog2(SAVE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             Cond,
    input  logic [3:0]             ALUFlags,
    input  logic [FLAG_GROUPS-1:0] FlagW,
    input  logic                   PCS,
    input  logic                   RegW,
    input  logic                   MemW,
    input  logic                   NoWrite,
    input  logic                   FlagSave,
    input  logic                   FlagRestore,
    output logic                   PCSrc,
    output logic                   RegWrite,
    output logic                   MemWrite,
    output logic                   CondEx,
    output logic [3:0]             Flags,
    output logic                   carry,
    output logic [DW-1:0]          StackDepth,
    output logic                   StackFull,
    output logic                   StackEmpty,
    output logic                   StackErr
);
    localparam int GW = 4 / FLAG_GROUPS;

    logic [3:0] stack [SAVE_DEPTH];
    logic [3:0] flags_next;
    logic [3:0] top_val;
    logic       n, z, c, v;
    logic       push_req, pop_req;

    assign {n, z, c, v} = Flags;

    // Condition uses committed flags only; ALUFlags are deliberately not forwarded.
    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            4'h0: CondEx = z;
            4'h1: CondEx = ~z;
            4'h2: CondEx = c;
            4'h3: CondEx = ~c;
            4'h4: CondEx = n;
            4'h5: CondEx = ~n;
            4'h6: CondEx = v;
            4'h7: CondEx = ~v;
            4'h8: CondEx = c & ~z;
            4'h9: CondEx = ~c | z;
            4'hA: CondEx = (n == v);
            4'hB: CondEx = (n != v);
            4'hC: CondEx = ~z & (n == v);
            4'hD: CondEx = z | (n != v);
            default: CondEx = 1'b1;
        endcase
    end

    assign PCSrc      = PCS & CondEx;
    assign RegWrite   = RegW & CondEx & ~NoWrite;
    assign MemWrite   = MemW & CondEx;
    assign carry      = Flags[1];
    assign StackFull  = (StackDepth == DW'(SAVE_DEPTH));
    assign StackEmpty = (StackDepth == '0);
    assign push_req   = FlagSave & ~FlagRestore;
    assign pop_req    = FlagRestore & ~FlagSave;

    always_comb begin
        flags_next = Flags;
        for (int g = 0; g < FLAG_GROUPS; g++) begin
            if (FlagW[g] && CondEx)
                flags_next[g*GW +: GW] = ALUFlags[g*GW +: GW];
        end
    end

    always_comb begin
        top_val = '0;
        for (int i = 0; i < SAVE_DEPTH; i++) begin
            if (DW'(i) == StackDepth - DW'(1))
                top_val = stack[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags      <= '0;
            StackDepth <= '0;
            StackErr   <= 1'b0;
            for (int i = 0; i < SAVE_DEPTH; i++)
                stack[i] <= '0;
        end else begin
            // A successful pop wins over any same-cycle group write.
            if (pop_req && !StackEmpty)
                Flags <= top_val;
            else
                Flags <= flags_next;

            if (push_req && !StackFull) begin
                for (int i = 0; i < SAVE_DEPTH; i++) begin
                    if (DW'(i) == StackDepth)
                        stack[i] <= Flags;
                end
                StackDepth <= StackDepth + DW'(1);
            end else if (pop_req && !StackEmpty) begin
                StackDepth <= StackDepth - DW'(1);
            end

            if ((push_req && StackFull) || (pop_req && StackEmpty) ||
                (FlagSave && FlagRestore))
                StackErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_condlogic_stack.sv
// Directed bench for condlogic_stack: expected values queued at stimulus time,
// popped and checked with immediate assertions when outputs are sampled.
module tb_condlogic_stack;
    localparam int FLAG_GROUPS = 2;
    localparam int SAVE_DEPTH  = 4;
    localparam int DW = $clog2(SAVE_DEPTH + 1);

    logic                   clk, reset;
    logic [3:0]             Cond, ALUFlags;
    logic [FLAG_GROUPS-1:0] FlagW;
    logic                   PCS, RegW, MemW, NoWrite, FlagSave, FlagRestore;
    logic                   PCSrc, RegWrite, MemWrite, CondEx, carry;
    logic [3:0]             Flags;
    logic [DW-1:0]          StackDepth;
    logic                   StackFull, StackEmpty, StackErr;

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    condlogic_stack #(.FLAG_GROUPS(FLAG_GROUPS), .SAVE_DEPTH(SAVE_DEPTH)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .FlagSave(FlagSave), .FlagRestore(FlagRestore),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .carry(carry), .StackDepth(StackDepth),
        .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cc)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            default: return 1'b1;
        endcase
    endfunction

    task automatic expect_val(input logic [7:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic idle();
        Cond = 4'hE; ALUFlags = 4'h0; FlagW = '0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; FlagSave = 0; FlagRestore = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle();
        FlagW = 2'b11; ALUFlags = f;
        tick();
        idle();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // 1: reset state
        #3;
        Cond = 4'h0;
        expect_val(8'h0); #1 chk("reset_condex_eq", 8'(CondEx));
        Cond = 4'hE;
        expect_val(8'h1); #1 chk("reset_condex_al", 8'(CondEx));
        expect_val(8'h0); chk("reset_flags", 8'(Flags));
        expect_val(8'h0); chk("reset_carry", 8'(carry));
        expect_val(8'h0); chk("reset_depth", 8'(StackDepth));
        expect_val(8'h1); chk("reset_empty", 8'(StackEmpty));
        expect_val(8'h0); chk("reset_full", 8'(StackFull));
        expect_val(8'h0); chk("reset_err", 8'(StackErr));
        @(negedge clk);
        reset = 1'b0;

        // 2: flag write and write gating
        idle();
        FlagW = 2'b11; ALUFlags = 4'b0110;
        expect_val(8'h6); expect_val(8'h1);
        tick();
        chk("t2_flags", 8'(Flags));
        chk("t2_carry", 8'(carry));
        idle();
        Cond = 4'h0; RegW = 1; NoWrite = 0; PCS = 1;
        expect_val(8'h1); expect_val(8'h1);
        #1 chk("t2_regwrite", 8'(RegWrite));
        chk("t2_pcsrc", 8'(PCSrc));
        NoWrite = 1;
        expect_val(8'h0); #1 chk("t2_regwrite_nowrite", 8'(RegWrite));

        // 3: failed condition blocks writes; per-group flag write
        idle();
        Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b1001; MemW = 1;
        expect_val(8'h0); expect_val(8'h0);
        #1 chk("t3_memwrite", 8'(MemWrite));
        chk("t3_condex", 8'(CondEx));
        expect_val(8'h6);
        tick();
        chk("t3_flags_held", 8'(Flags));
        idle();
        FlagW = 2'b01; ALUFlags = 4'b1001;
        expect_val(8'h5);
        tick();
        chk("t3_group0_only", 8'(Flags));
        idle();
        FlagW = 2'b10; ALUFlags = 4'b1010;
        expect_val(8'h9);
        tick();
        chk("t3_group1_only", 8'(Flags));

        // condition sweep over all flag values
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int cc = 0; cc < 16; cc++) begin
                Cond = 4'(cc);
                expect_val(8'(cond_ref(4'(cc), 4'(f))));
                #1 chk($sformatf("cond_%0h_flags_%0h", cc, f), 8'(CondEx));
            end
        end

        // 4: fill, overflow, drain, underflow
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            set_flags(4'b1000 >> i);
            FlagSave = 1;
            expect_val(8'(i + 1));
            tick();
            chk($sformatf("t4_push_depth_%0d", i), 8'(StackDepth));
        end
        idle();
        expect_val(8'h1); #1 chk("t4_full", 8'(StackFull));
        FlagSave = 1;
        expect_val(8'h1); expect_val(8'h4); expect_val(8'h1);
        tick();
        chk("t4_overflow_err", 8'(StackErr));
        chk("t4_overflow_depth", 8'(StackDepth));
        chk("t4_overflow_flags", 8'(Flags));
        for (int i = 0; i < 4; i++) begin
            idle();
            FlagRestore = 1;
            expect_val(8'(4'b0001 << i));
            tick();
            chk($sformatf("t4_pop_%0d", i), 8'(Flags));
        end
        idle();
        expect_val(8'h1); #1 chk("t4_empty", 8'(StackEmpty));
        FlagRestore = 1;
        expect_val(8'h8); expect_val(8'h1); expect_val(8'h0);
        tick();
        chk("t4_underflow_flags", 8'(Flags));
        chk("t4_underflow_err", 8'(StackErr));
        chk("t4_underflow_depth", 8'(StackDepth));
        idle();
        FlagRestore = 1; FlagW = 2'b11; ALUFlags = 4'b0011;
        expect_val(8'h3);
        tick();
        chk("t4_underflow_flagw", 8'(Flags));

        // 5: push with same-cycle write, pop overriding write
        idle();
        FlagSave = 1; FlagW = 2'b11; ALUFlags = 4'b1100;
        expect_val(8'hC); expect_val(8'h1);
        tick();
        chk("t5_push_flags", 8'(Flags));
        chk("t5_push_depth", 8'(StackDepth));
        idle();
        FlagRestore = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
        expect_val(8'h3); expect_val(8'h0);
        tick();
        chk("t5_pop_flags", 8'(Flags));
        chk("t5_pop_depth", 8'(StackDepth));

        // 6: simultaneous save/restore, then asynchronous reset
        pulse_reset();
        set_flags(4'b0101);
        FlagSave = 1; tick();
        set_flags(4'b0110);
        FlagSave = 1;
        expect_val(8'h2); expect_val(8'h0);
        tick();
        chk("t6_depth2", 8'(StackDepth));
        chk("t6_err_clear", 8'(StackErr));
        idle();
        FlagSave = 1; FlagRestore = 1; FlagW = 2'b11; ALUFlags = 4'b1010;
        expect_val(8'h2); expect_val(8'h1); expect_val(8'hA);
        tick();
        chk("t6_both_depth", 8'(StackDepth));
        chk("t6_both_err", 8'(StackErr));
        chk("t6_both_flags", 8'(Flags));
        idle();
        #2 reset = 1'b1;
        expect_val(8'h0); expect_val(8'h0); expect_val(8'h0); expect_val(8'h1);
        #1;
        chk("t6_async_flags", 8'(Flags));
        chk("t6_async_depth", 8'(StackDepth));
        chk("t6_async_err", 8'(StackErr));
        chk("t6_async_empty", 8'(StackEmpty));
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
